// File: rtl/tdc_count_ctrl.sv
// tdc_count_ctrl: unwraps the 7-bit TDC ripple counter into a wide DCO phase word.
// Optional range checker enabled by defining TDC_CTRL_RANGE_CHK_EN.
module tdc_count_ctrl #(
    parameter int ACC_W  = 24,
    parameter int SETTLE = 2,
    parameter int DMIN   = 1,
    parameter int DMAX   = 126
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       count,
    output logic [6:0]       delta,
    output logic             delta_vld,
    output logic [ACC_W-1:0] phase,
    output logic             phase_vld,
    output logic [1:0]       state,
    output logic             range_err
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SETTLE, S_TRACK} state_t;

    state_t     cur, nxt;
    logic [6:0] prev, diff;
    logic [3:0] cnt;

    if (ACC_W < 8 || ACC_W > 32 || SETTLE < 0 || SETTLE > 15 || DMIN < 0 || DMAX > 127 || DMIN > DMAX) begin : g_bad_param
        $error("tdc_count_ctrl: illegal parameter combination");
    end

    assign state = cur;
    assign diff  = count - prev;

    // state register
    always_ff @(posedge clk) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    // next state: dropping en always returns to IDLE so a restart re-primes
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = en ? S_PRIME : S_IDLE;
            S_PRIME:  nxt = !en ? S_IDLE : (SETTLE == 0 ? S_TRACK : S_SETTLE);
            S_SETTLE: nxt = !en ? S_IDLE : (cnt <= 4'd1 ? S_TRACK : S_SETTLE);
            default:  nxt = en ? S_TRACK : S_IDLE;
        endcase
    end

    // datapath: prime prev, discard settling increments, then accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            cnt       <= '0;
            delta     <= '0;
            delta_vld <= 1'b0;
            phase     <= '0;
            phase_vld <= 1'b0;
        end else if (!en) begin
            delta_vld <= 1'b0;
            phase_vld <= 1'b0;
        end else begin
            case (cur)
                S_PRIME: begin
                    prev      <= count;
                    phase     <= '0;
                    cnt       <= 4'(SETTLE);
                    delta_vld <= 1'b0;
                    phase_vld <= 1'b0;
                end
                S_SETTLE: begin
                    delta <= diff;
                    prev  <= count;
                    cnt   <= cnt - 4'd1;
                end
                S_TRACK: begin
                    delta     <= diff;
                    prev      <= count;
                    delta_vld <= 1'b1;
                    phase     <= phase + {{(ACC_W-7){1'b0}}, diff};
                    phase_vld <= 1'b1;
                end
                default: begin
                    delta_vld <= 1'b0;
                    phase_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef TDC_CTRL_RANGE_CHK_EN
    localparam logic [6:0] DLO = 7'(DMIN);
    localparam logic [6:0] DHI = 7'(DMAX);

    // sticky flag for implausible tracked increments, cleared by reset or en low
    always_ff @(posedge clk) begin
        if (rst || !en)                                        range_err <= 1'b0;
        else if (cur == S_TRACK && (diff < DLO || diff > DHI)) range_err <= 1'b1;
    end
`else
    assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdc_count_ctrl.sv
// tb_tdc_count_ctrl: table-driven check of the TDC counter sequencer/unwrapper.
module tb_tdc_count_ctrl;
    typedef struct {
        logic       rst;
        logic       en;
        logic [6:0] count;
        int         st, dl, dv, ph, pv, re;
    } vec_t;

`ifdef TDC_CTRL_RANGE_CHK_EN
    localparam bit RE_ON = 1'b1;
`else
    localparam bit RE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [6:0]  count = '0;
    logic [6:0]  delta, delta8;
    logic        delta_vld, delta_vld8, phase_vld, phase_vld8, range_err, range_err8;
    logic [23:0] phase;
    logic [7:0]  phase8;
    logic [1:0]  state, state8;

    int total = 0;
    int bad = 0;
    vec_t vq[$];

    tdc_count_ctrl #(.ACC_W(24), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .en(en), .count(count),
        .delta(delta), .delta_vld(delta_vld), .phase(phase), .phase_vld(phase_vld),
        .state(state), .range_err(range_err)
    );

    tdc_count_ctrl #(.ACC_W(8), .SETTLE(0)) dut8 (
        .clk(clk), .rst(rst), .en(en), .count(count),
        .delta(delta8), .delta_vld(delta_vld8), .phase(phase8), .phase_vld(phase_vld8),
        .state(state8), .range_err(range_err8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input int c,
                       input int st, input int dl, input int dv, input int ph, input int pv, input int re);
        vec_t v;
        v.rst = r; v.en = e; v.count = 7'(c);
        v.st = st; v.dl = dl; v.dv = dv; v.ph = ph; v.pv = pv; v.re = re;
        vq.push_back(v);
    endtask

    task automatic step(input logic r, input logic e, input int c);
        @(negedge clk);
        rst = r; en = e; count = 7'(c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst en count   st dl dv  ph  pv re
        add(1, 1,   0,      0, 0, 0,   0, 0, 0);
        add(1, 1,   0,      0, 0, 0,   0, 0, 0);
        add(0, 1,  10,      1, 0, 0,   0, 0, 0);
        add(0, 1,  10,      2, 0, 0,   0, 0, 0);
        add(0, 1,  50,      2, 40, 0,  0, 0, 0);
        add(0, 1,  90,      3, 40, 0,  0, 0, 0);
        add(0, 1,   2,      3, 40, 1,  40, 1, 0);
        add(0, 1,  42,      3, 40, 1,  80, 1, 0);
        add(0, 1,  82,      3, 40, 1, 120, 1, 0);
        add(0, 1, 100,      3, 18, 1, 138, 1, 0);
        add(0, 1, 120,      3, 20, 1, 158, 1, 0);
        add(0, 1,  12,      3, 20, 1, 178, 1, 0);
        add(0, 1,  32,      3, 20, 1, 198, 1, 0);
        add(0, 1,  32,      3, 0, 1,  198, 1, 1);
        add(0, 1,  40,      3, 8, 1,  206, 1, 1);
        add(0, 0,  50,      0, 8, 0,  206, 0, 0);
        add(0, 0,  50,      0, 8, 0,  206, 0, 0);
        add(0, 1,  60,      1, 8, 0,  206, 0, 0);
        add(0, 1,  60,      2, 8, 0,   0, 0, 0);
        add(0, 1,  70,      2, 10, 0,  0, 0, 0);
        add(0, 0,  80,      0, 10, 0,  0, 0, 0);
        add(0, 1,  80,      1, 10, 0,  0, 0, 0);
        add(0, 1,  80,      2, 10, 0,  0, 0, 0);
        add(0, 1,  85,      2, 5, 0,   0, 0, 0);
        add(0, 1,  90,      3, 5, 0,   0, 0, 0);
        add(0, 1,  95,      3, 5, 1,   5, 1, 0);
        add(1, 1, 100,      0, 0, 0,   0, 0, 0);
        add(0, 1, 100,      1, 0, 0,   0, 0, 0);
        add(0, 1, 100,      2, 0, 0,   0, 0, 0);
        add(1, 1, 110,      0, 0, 0,   0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, int'(vq[i].count));
            chk("state", i, int'(state), vq[i].st);
            chk("delta", i, int'(delta), vq[i].dl);
            chk("delta_vld", i, int'(delta_vld), vq[i].dv);
            chk("phase", i, int'(phase), vq[i].ph);
            chk("phase_vld", i, int'(phase_vld), vq[i].pv);
            chk("range_err", i, int'(range_err), RE_ON ? vq[i].re : 0);
        end

        step(1, 0, 0);
        chk("w8_reset_phase", 0, int'(phase8), 0);
        step(0, 1, 0);
        chk("w8_prime_state", 0, int'(state8), 1);
        step(0, 1, 0);
        chk("w8_track_state", 0, int'(state8), 3);
        chk("w8_dvld_before", 0, int'(delta_vld8), 0);
        step(0, 1, 100);
        chk("w8_phase", 1, int'(phase8), 100);
        chk("w8_delta", 1, int'(delta8), 100);
        chk("w8_dvld", 1, int'(delta_vld8), 1);
        step(0, 1, 72);
        chk("w8_phase", 2, int'(phase8), 200);
        step(0, 1, 44);
        chk("w8_phase", 3, int'(phase8), 44);
        chk("w8_delta", 3, int'(delta8), 100);
        step(0, 0, 44);
        chk("w8_idle_state", 0, int'(state8), 0);
        chk("w8_idle_hold", 0, int'(phase8), 44);
        chk("w8_idle_pvld", 0, int'(phase_vld8), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
